// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
// ov7670_pkg : shared markers and sequencer state encoding for OV7670 config
// Revision   : 1.0
// ============================================================================
package ov7670_pkg;

  localparam logic [15:0] OV_END_MARKER   = 16'hFFFF;
  localparam logic [15:0] OV_DELAY_MARKER = 16'hFFF0;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_DECODE   = 3'd2,
    SEQ_SEND     = 3'd3,
    SEQ_HOLD     = 3'd4,
    SEQ_WAIT_RDY = 3'd5,
    SEQ_DELAY    = 3'd6,
    SEQ_FIN      = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ov7670_config_seq.sv
`default_nettype none
// ============================================================================
// ov7670_config_seq : walks the config ROM, issuing one SCCB write per entry
// Revision          : 1.0
// ============================================================================
module ov7670_config_seq
  import ov7670_pkg::*;
#(
  parameter int DELAY_CYCLES = 250_000,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_start,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done
);

  localparam int              CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_advance;
  logic             r_auto_pend;
  logic [7:0]       r_rom_addr;
  logic [7:0]       r_sccb_addr;
  logic [7:0]       r_sccb_data;
  logic             r_busy;
  logic             r_done;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_advance = 1'b0;
    case (r_state)
      SEQ_IDLE:     if (start || r_auto_pend) w_next = SEQ_FETCH;
      SEQ_FETCH:    w_next = SEQ_DECODE;
      SEQ_DECODE: begin
        if (rom_dout == OV_END_MARKER) begin
          w_next = SEQ_FIN;
        end else if (rom_dout == OV_DELAY_MARKER) begin
          w_next    = SEQ_DELAY;
          w_cnt_nxt = CNT_LOAD;
        end else begin
          w_next = SEQ_SEND;
        end
      end
      SEQ_SEND:     if (sccb_ready) w_next = SEQ_HOLD;
      // The master drops ready one cycle late, so the accept cycle's ready is stale here.
      SEQ_HOLD:     w_next = SEQ_WAIT_RDY;
      SEQ_WAIT_RDY: if (sccb_ready) w_advance = 1'b1;
      SEQ_DELAY: begin
        if (r_cnt == '0) w_advance = 1'b1;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      SEQ_FIN:      w_next = SEQ_IDLE;
      default:      w_next = SEQ_IDLE;
    endcase
    // Address FF is the last table slot; the run ends rather than wrapping.
    if (w_advance) w_next = (r_rom_addr == 8'hFF) ? SEQ_FIN : SEQ_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_cnt       <= '0;
      r_auto_pend <= AUTO_START;
      r_rom_addr  <= 8'h00;
      r_sccb_addr <= 8'h00;
      r_sccb_data <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == SEQ_IDLE && w_next == SEQ_FETCH) begin
        r_rom_addr  <= 8'h00;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_auto_pend <= 1'b0;
      end
      if (w_advance && r_rom_addr != 8'hFF) r_rom_addr <= r_rom_addr + 8'd1;
      if (r_state == SEQ_DECODE && w_next == SEQ_SEND) begin
        r_sccb_addr <= rom_dout[15:8];
        r_sccb_data <= rom_dout[7:0];
      end
      if (w_next == SEQ_FIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign sccb_start = (r_state == SEQ_SEND);
  assign sccb_addr  = r_sccb_addr;
  assign sccb_data  = r_sccb_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_seq.sv
`default_nettype none
// ============================================================================
// tb_ov7670_config_seq : directed bench with ROM and SCCB master models
// Revision             : 1.0
// ============================================================================
module tb_ov7670_config_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = 16'h0000;
  logic        sccb_start;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];
  int          r_mcnt = 0;
  logic        force_low = 1'b0;
  int          cyc = 0;
  logic [7:0]  q_addr[$];
  logic [7:0]  q_data[$];
  logic [7:0]  q_ra[$];
  int          q_cyc[$];
  logic        wrap = 1'b0;
  logic [7:0]  prev_ra = 8'h00;
  logic        prev_busy = 1'b0;

  ov7670_config_seq #(.DELAY_CYCLES(16), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .sccb_start(sccb_start), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_ready(sccb_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom[rom_addr];

  // SCCB master: ready lingers one cycle after accept, then 20 cycles busy.
  assign sccb_ready = !force_low && (r_mcnt == 0 || r_mcnt == 21);
  always @(posedge clk) begin
    if (sccb_start && sccb_ready) r_mcnt <= 21;
    else if (r_mcnt > 0)          r_mcnt <= r_mcnt - 1;
  end

  always @(posedge clk) begin
    if (sccb_start && sccb_ready) begin
      q_addr.push_back(sccb_addr);
      q_data.push_back(sccb_data);
      q_ra.push_back(rom_addr);
      q_cyc.push_back(cyc);
    end
    if (busy && prev_busy && prev_ra != 8'h00 && rom_addr == 8'h00) wrap = 1'b1;
    prev_ra   = rom_addr;
    prev_busy = busy;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    tick();
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_ra.delete();
    q_cyc.delete();
  endtask

  task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, {24'd0, rom_addr}, 32'h0);
    chk({tag, "_sccb_start"}, {31'd0, sccb_start}, 32'h0);
    chk({tag, "_sccb_addr"}, {24'd0, sccb_addr}, 32'h0);
    chk({tag, "_sccb_data"}, {24'd0, sccb_data}, 32'h0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'h0);
    chk({tag, "_done"}, {31'd0, done}, 32'h0);
  endtask

  initial begin
    int   c;
    int   n;
    logic ok_s, ok_a, ok_d, ok_r;

    // Reset values and auto-started three-write table.
    load_rom(16'h1280, 16'h1204, 16'h1140, 16'hFFFF);
    tick(); tick(); tick();
    chk_reset_vals("rst");
    clear_log();
    rst = 1'b0;
    wait_done("t1_done", 500);
    chk("t1_count", q_addr.size(), 3);
    chk("t1_w0", {q_addr[0], q_data[0]}, 16'h1280);
    chk("t1_w1", {q_addr[1], q_data[1]}, 16'h1204);
    chk("t1_w2", {q_addr[2], q_data[2]}, 16'h1140);
    chk("t1_gap", q_cyc[1] - q_cyc[0], 25);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Restart after done, start latency, and mid-run start ignored.
    tick(); tick();
    clear_log();
    c = cyc;
    pulse_start();
    chk("t2_done_drop", {31'd0, done}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_rom_addr", {24'd0, rom_addr}, 32'd0);
    n = 0;
    while (q_addr.size() < 1 && n < 50) begin tick(); n++; end
    chk("t2_latency", q_cyc[0], c + 3);
    repeat (5) tick();
    pulse_start();
    wait_done("t2_done", 500);
    chk("t2_count", q_addr.size(), 3);
    chk("t2_w0", {q_addr[0], q_data[0]}, 16'h1280);
    chk("t2_w2", {q_addr[2], q_data[2]}, 16'h1140);

    // Delay entry.
    load_rom(16'h1280, 16'hFFF0, 16'h1355, 16'hFFFF);
    tick();
    clear_log();
    pulse_start();
    wait_done("t3_done", 500);
    chk("t3_count", q_addr.size(), 2);
    chk("t3_w1", {q_addr[1], q_data[1]}, 16'h1355);
    chk("t3_gap", q_cyc[1] - q_cyc[0], 43);

    // Ready held low throughout SEND.
    load_rom(16'h1280, 16'h2A3B, 16'hFFFF, 16'hFFFF);
    force_low = 1'b1;
    tick();
    clear_log();
    pulse_start();
    n = 0;
    while (sccb_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t4_send", {31'd0, sccb_start}, 32'd1);
    ok_s = 1'b1; ok_a = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sccb_start !== 1'b1)  ok_s = 1'b0;
      if (sccb_addr !== 8'h12)  ok_a = 1'b0;
      if (sccb_data !== 8'h80)  ok_d = 1'b0;
      if (rom_addr !== 8'h00)   ok_r = 1'b0;
    end
    chk("t4_hold_start", {31'd0, ok_s}, 32'd1);
    chk("t4_hold_addr", {31'd0, ok_a}, 32'd1);
    chk("t4_hold_data", {31'd0, ok_d}, 32'd1);
    chk("t4_hold_rom_addr", {31'd0, ok_r}, 32'd1);
    chk("t4_no_accept", q_addr.size(), 0);
    force_low = 1'b0;
    wait_done("t4_done", 500);
    chk("t4_count", q_addr.size(), 2);
    chk("t4_w0", {q_ra[0], q_addr[0], q_data[0]}, 24'h001280);
    chk("t4_w1", {q_addr[1], q_data[1]}, 16'h2A3B);

    // Reset during DELAY, then automatic restart.
    load_rom(16'h1280, 16'hFFF0, 16'h1355, 16'hFFFF);
    tick();
    clear_log();
    pulse_start();
    n = 0;
    while (q_addr.size() < 1 && n < 50) begin tick(); n++; end
    repeat (30) tick();
    chk("t5_in_delay", {busy, sccb_start}, 2'b10);
    rst = 1'b1;
    tick();
    chk_reset_vals("t5_rst");
    clear_log();
    rst = 1'b0;
    wait_done("t5_done", 500);
    chk("t5_count", q_addr.size(), 2);
    chk("t5_w0", {q_ra[0], q_addr[0], q_data[0]}, 24'h001280);

    // Full 256-entry table without an end marker.
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    tick();
    clear_log();
    wrap = 1'b0;
    pulse_start();
    wait_done("t6_done", 10000);
    chk("t6_count", q_addr.size(), 256);
    ok_a = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] !== 8'(i))  ok_a = 1'b0;
      if (q_data[i] !== ~8'(i)) ok_d = 1'b0;
      if (q_ra[i] !== 8'(i))    ok_r = 1'b0;
    end
    chk("t6_addrs", {31'd0, ok_a}, 32'd1);
    chk("t6_data", {31'd0, ok_d}, 32'd1);
    chk("t6_rom_addr", {31'd0, ok_r}, 32'd1);
    chk("t6_no_wrap", {31'd0, wrap}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
